// File: rtl/fifo_pack.sv
// Narrow-to-wide packing FIFO: pairs of DATA_WIDTH writes are read back as one 2*DATA_WIDTH word (first-word fall-through).
// Optional build macro FIFO_PACK_MSB_FIRST_EN places the first entry of each pair in the upper half of r_data.
module fifo_pack #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic                      rd,
    output logic [2*DATA_WIDTH-1:0]   r_data,
    output logic                      full,
    output logic                      empty,
    output logic                      partial
);
    localparam int SLOTS = 2 ** (ADDR_WIDTH + 1);
    localparam int CW    = ADDR_WIDTH + 2;
    localparam int WW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]         CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]         CNT_TWO   = CW'(2);
    localparam logic [CW-1:0]         CNT_MAX   = CW'(SLOTS);
    localparam logic [WW-1:0]         WPTR_ZERO = WW'(0);
    localparam logic [WW-1:0]         WPTR_ONE  = WW'(1);
    localparam logic [ADDR_WIDTH-1:0] RPTR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] RPTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_r [SLOTS];
    logic [WW-1:0]         wptr_r;
    logic [ADDR_WIDTH-1:0] rptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;
    logic                  wr_ok_s;
    logic                  rd_ok_s;
    logic [DATA_WIDTH-1:0] lo_slot_s;
    logic [DATA_WIDTH-1:0] hi_slot_s;

    // Flags depend only on the registered occupancy count.
    assign full    = (count_r == CNT_MAX);
    assign empty   = (count_r < CNT_TWO);
    assign partial = count_r[0];

    // Acceptance from pre-edge flags and the resulting occupancy.
    always_comb begin
        wr_ok_s      = wr & ~full;
        rd_ok_s      = rd & ~empty;
        count_next_s = count_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_TWO;
            2'b11:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointer and count registers; reset overrides any concurrent request.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r  <= WPTR_ZERO;
            rptr_r  <= RPTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_next_s;
            if (wr_ok_s) begin
                wptr_r <= wptr_r + WPTR_ONE;
            end
            if (rd_ok_s) begin
                rptr_r <= rptr_r + RPTR_ONE;
            end
        end
    end

    // Storage write port; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok_s) begin
            mem_r[wptr_r] <= w_data;
        end
    end

    assign lo_slot_s = mem_r[{rptr_r, 1'b0}];
    assign hi_slot_s = mem_r[{rptr_r, 1'b1}];

`ifdef FIFO_PACK_MSB_FIRST_EN
    assign r_data = {lo_slot_s, hi_slot_s};
`else
    assign r_data = {hi_slot_s, lo_slot_s};
`endif

endmodule

// File: tb/tb_fifo_pack.sv
// Scoreboard bench for fifo_pack: a queue-based model predicts flags and packed words, a negedge monitor compares.
module tb_fifo_pack;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr;
    logic [3:0] w_data;
    logic       rd;
    logic [7:0] r_data;
    logic       full;
    logic       empty;
    logic       partial;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] nq [$];
    logic [7:0] exp_q [$];
    logic [3:0] pend;
    bit         pend_valid = 1'b0;
    bit         armed = 1'b0;

    fifo_pack #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(r_data), .full(full), .empty(empty), .partial(partial)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pack2(input logic [3:0] first, input logic [3:0] second);
`ifdef FIFO_PACK_MSB_FIRST_EN
        return {first, second};
`else
        return {second, first};
`endif
    endfunction

    // Reference model: a FIFO of narrow entries; every second accepted write yields a wide word.
    always @(posedge clk) begin
        bit wacc;
        bit racc;
        if (reset) begin
            nq.delete();
            exp_q.delete();
            pend_valid = 1'b0;
            armed = 1'b1;
        end else if (armed) begin
            racc = rd && (nq.size() >= 2);
            wacc = wr && (nq.size() < 8);
            if (racc) begin
                void'(nq.pop_front());
                void'(nq.pop_front());
            end
            if (wacc) begin
                nq.push_back(w_data);
                if (pend_valid) begin
                    exp_q.push_back(pack2(pend, w_data));
                    pend_valid = 1'b0;
                end else begin
                    pend = w_data;
                    pend_valid = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: flags every cycle, head word whenever the DUT presents one.
    always @(negedge clk) begin
        if (armed) begin
            check("empty", {7'd0, empty}, {7'd0, nq.size() < 2});
            check("full", {7'd0, full}, {7'd0, nq.size() == 8});
            check("partial", {7'd0, partial}, {7'd0, nq.size() % 2 == 1});
            if (!empty) begin
                if (exp_q.size() == 0) begin
                    check("r_data_unexpected", r_data, 8'hxx);
                end else begin
                    check("r_data", r_data, exp_q[0]);
                    if (rd && !reset) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc(input logic w, input logic [3:0] d, input logic r, input logic rs);
        wr = w;
        w_data = d;
        rd = r;
        reset = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        wr = 1'b0; rd = 1'b0; w_data = 4'h0; reset = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        // Single pair then pop.
        cyc(1'b1, 4'h1, 1'b0, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        // Fill to full, overflow write, drain, underflow read.
        for (int i = 1; i <= 9; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        // Read while partial is ignored; full with wr and rd together.
        cyc(1'b1, 4'h9, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        cyc(1'b1, 4'hA, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 4'(i + 3), 1'b0, 1'b0);
        cyc(1'b1, 4'hF, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
        // Reset discards a held partial entry.
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i + 5), 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        cyc(1'b1, 4'h3, 1'b0, 1'b0);
        cyc(1'b1, 4'h4, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0);
        // Wrap: 12 writes interleaved with 6 reads.
        for (int i = 0; i < 12; i++) cyc(1'b1, 4'(i + 1), (i % 2) == 1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 99) < 55), 4'($urandom), 1'($urandom_range(0, 99) < 45),
                1'($urandom_range(0, 199) == 0));
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_pack.md
FIFO_PACK -- requirements
Module: fifo_pack

Interface
REQ-001: Parameter DATA_WIDTH, default 4, width of one write (narrow) entry in bits.
REQ-002: Parameter ADDR_WIDTH, default 2, log2 of the storage depth in read (wide) words, giving 2**ADDR_WIDTH words of 2*DATA_WIDTH bits.
REQ-003: Port clk, input, 1 bit, single clock, all state updates on rising edge.
REQ-004: Port reset, input, 1 bit, synchronous active-high reset.
REQ-005: Port wr, input, 1 bit, write request for w_data this cycle.
REQ-006: Port w_data, input, DATA_WIDTH bits, narrow write entry.
REQ-007: Port rd, input, 1 bit, read request (pop) of head wide word.
REQ-008: Port r_data, output, 2*DATA_WIDTH bits, head wide word, valid whenever empty=0.
REQ-009: Port full, output, 1 bit, no space for one more narrow entry.
REQ-010: Port empty, output, 1 bit, no complete wide word available.
REQ-011: Port partial, output, 1 bit, an odd narrow entry is held awaiting its pair.

Function
REQ-012: The block SHALL pack two consecutive accepted narrow writes into one wide word; default order is first entry in r_data[DATA_WIDTH-1:0], second entry in r_data[2*DATA_WIDTH-1:DATA_WIDTH].
REQ-013: Storage SHALL be 2**(ADDR_WIDTH+1) narrow slots; write pointer ADDR_WIDTH+1 bits in narrow units, read pointer ADDR_WIDTH bits in wide units, both wrapping modulo depth.
REQ-014: An occupancy count of ADDR_WIDTH+2 bits in narrow units SHALL track stored entries, range 0 to 2**(ADDR_WIDTH+1).
REQ-015: full SHALL be 1 iff count = 2**(ADDR_WIDTH+1); empty SHALL be 1 iff count < 2; partial SHALL equal count[0]; all are registered or derived from registered count only.
REQ-016: A write SHALL be accepted iff wr=1 and full=0 at the clock edge; accepted write stores w_data and increments write pointer and count by 1.
REQ-017: A read SHALL be accepted iff rd=1 and empty=0 at the clock edge; accepted read advances read pointer by 1 and decrements count by 2.
REQ-018: Acceptance SHALL be decided from pre-edge state; simultaneous accepted write and read SHALL change count by -1.
REQ-019: wr while full SHALL be ignored without corruption; rd while empty SHALL be ignored, including when partial=1.
REQ-020: When full=1 and wr=rd=1, the read SHALL be accepted and the write dropped.
REQ-021: r_data SHALL be read combinationally from the storage at the read pointer (first-word fall-through, zero-cycle read latency); value is undefined-but-stable while empty=1.
REQ-022: Latency from the edge accepting the second narrow entry of a pair to empty=0 SHALL be zero additional cycles (visible after that same edge).

Reset
REQ-023: reset=1 at a rising edge SHALL clear both pointers and count, giving empty=1, full=0, partial=0 after that edge, discarding any held entry including a partial one.
REQ-024: reset SHALL take priority over simultaneous wr and rd; storage contents need not be cleared.

Configuration
REQ-025: Macro FIFO_PACK_MSB_FIRST_EN, when defined, SHALL place the first narrow entry of each pair in r_data[2*DATA_WIDTH-1:DATA_WIDTH] and the second in the low half; when undefined, REQ-012 order applies; flags and timing identical in both builds.

Verification (DATA_WIDTH=4, ADDR_WIDTH=2, 8 narrow slots, macro undefined unless stated)
REQ-026: Reset asserted one cycle -> empty=1, full=0, partial=0.
REQ-027: Write 4'h1 then 4'h2 -> partial=1 after first, empty=0 and r_data=8'h21 after second; one rd -> empty=1, partial=0.
REQ-028: Write 4'h1..4'h8 then 4'h9 -> full=1 after 8th, 9th ignored; four reads yield 8'h21, 8'h43, 8'h65, 8'h87, then empty=1; fifth rd ignored.
REQ-029: Write 4'h9, pulse rd -> rd ignored, empty=1, partial=1; write 4'hA -> r_data=8'hA9; full FIFO with wr=rd=1 -> read accepted, write dropped, count=6, partial=0.
REQ-030: Three narrow writes then reset mid-stream -> empty=1, partial=0; next writes 4'h3, 4'h4 -> r_data=8'h43; wrap test of 12 writes interleaved with 6 reads returns entries in order.
REQ-031: FIFO_PACK_MSB_FIRST_EN defined, write 4'h1 then 4'h2 -> r_data=8'h12.
